// File: rtl/xgriscv_lsu.sv
// Load/store unit between the M stage and a single-ported, variable-latency data memory.
// Define LSU_TIMEOUT_EN to bound BUSY at MAX_WAIT cycles and report a bus error via misalign.
module xgriscv_lsu #(
  parameter int ADDR_W   = 32,
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [1:0]        req_lwhb,
  input  logic [1:0]        req_swhb,
  input  logic              req_lu,
  output logic              stall,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [1:0] SzHalf = 2'b01;
  localparam logic [1:0] SzByte = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} lsuState_t;

  lsuState_t state, nextState;

  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              luQ;
  logic              weQ;
  logic [XLEN-1:0]   wdataQ;

  logic [1:0]        reqSize;
  logic              reqMisalign;
  logic [XLEN-1:0]   reqLanes;
  logic [XLEN-1:0]   laneData;
  logic [XLEN-1:0]   loadData;
  logic [3:0]        storeBe;
  logic              busy;
  logic              timeout;

  // Decode the incoming request: replicate store data across lanes and test alignment.
  always_comb begin
    reqSize     = req_we ? req_swhb : req_lwhb;
    reqLanes    = req_wdata;
    reqMisalign = 1'b0;
    case (reqSize)
      SzHalf: begin
        reqLanes    = {(XLEN/16){req_wdata[15:0]}};
        reqMisalign = req_addr[0];
      end
      SzByte: reqLanes = {(XLEN/8){req_wdata[7:0]}};
      default: reqMisalign = (req_addr[1:0] != 2'b00);
    endcase
  end

  // Bring the addressed lane down to bit 0 and extend it to the load size.
  always_comb begin
    laneData = mem_rdata >> {addrQ[1:0], 3'b000};
    case (sizeQ)
      SzByte:  loadData = luQ ? {{(XLEN-8){1'b0}}, laneData[7:0]}
                              : {{(XLEN-8){laneData[7]}}, laneData[7:0]};
      SzHalf:  loadData = luQ ? {{(XLEN-16){1'b0}}, laneData[15:0]}
                              : {{(XLEN-16){laneData[15]}}, laneData[15:0]};
      default: loadData = laneData;
    endcase
  end

  always_comb begin
    case (sizeQ)
      SzByte:  storeBe = 4'b0001 << addrQ[1:0];
      SzHalf:  storeBe = addrQ[1] ? 4'b1100 : 4'b0011;
      default: storeBe = 4'b1111;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CntW = $clog2(MAX_WAIT + 1);

  logic [CntW-1:0] waitCnt;

  // Counts BUSY cycles without an ack; cleared whenever the unit is outside BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (state != BUSY) begin
      waitCnt <= '0;
    end else if (!mem_ack) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  assign timeout = (state == BUSY) && !mem_ack && (waitCnt == CntW'(MAX_WAIT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // IDLE passes req_valid straight to stall so the core freezes in the request cycle.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    rsp_valid = 1'b0;
    misalign  = 1'b0;
    case (state)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          nextState = reqMisalign ? ERR : BUSY;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack) begin
          nextState = DONE;
        end else if (timeout) begin
          nextState = ERR;
        end
      end
      DONE: begin
        rsp_valid = !weQ;
        nextState = IDLE;
      end
      ERR: begin
        misalign  = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Request capture in IDLE; response capture on ack (loads) or on a bus timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrQ     <= '0;
      sizeQ     <= '0;
      luQ       <= 1'b0;
      weQ       <= 1'b0;
      wdataQ    <= '0;
      rsp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        addrQ  <= req_addr;
        sizeQ  <= reqSize;
        luQ    <= req_lu;
        weQ    <= req_we;
        wdataQ <= reqLanes;
      end
      if (state == BUSY && mem_ack && !weQ) begin
        rsp_rdata <= loadData;
      end else if (timeout) begin
        rsp_rdata <= XLEN'(32'hDEAD_BEEF);
      end
    end
  end

  assign busy      = (state == BUSY);
  assign mem_we    = busy && weQ;
  assign mem_addr  = busy ? {addrQ[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = (busy && weQ) ? storeBe : 4'b0000;
  assign mem_wdata = (busy && weQ) ? wdataQ : '0;

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Table-driven bench for xgriscv_lsu with a behavioural variable-latency memory,
// plus hand sequences for reset, out-of-BUSY acks and the long-wait/timeout case.
module tb_xgriscv_lsu;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_lwhb;
  logic [1:0]  req_swhb;
  logic        req_lu;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  xgriscv_lsu dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_lwhb  (req_lwhb),
    .req_swhb  (req_swhb),
    .req_lu    (req_lu),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .misalign  (misalign),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  lwhb;
    logic [1:0]  swhb;
    logic        lu;
    int          waitCycles;
    logic [31:0] rdata;
    int          expStall;
    logic        expRv;
    logic [31:0] expRdata;
    logic        expMis;
    logic        expReq;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic        expWe;
  } vec_t;

  vec_t vecs[$];

  int testsRun = 0;
  int testsFailed = 0;

  int          obsStall;
  logic        obsRv;
  logic [31:0] obsRdata;
  logic        obsMis;
  logic        obsReq;
  logic [31:0] obsAddr;
  logic [3:0]  obsBe;
  logic [31:0] obsWdata;
  logic        obsWe;
  int          obsUnstable;
  logic [3:0]  obsAfter;
  logic        obsHung;

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] lwhb, input logic [1:0] swhb, input logic lu,
                              input int waitCycles, input logic [31:0] rdata, input int expStall,
                              input logic expRv, input logic [31:0] expRdata, input logic expMis,
                              input logic expReq, input logic [31:0] expAddr, input logic [3:0] expBe,
                              input logic [31:0] expWdata, input logic expWe);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.lwhb = lwhb; v.swhb = swhb; v.lu = lu;
    v.waitCycles = waitCycles; v.rdata = rdata; v.expStall = expStall; v.expRv = expRv;
    v.expRdata = expRdata; v.expMis = expMis; v.expReq = expReq; v.expAddr = expAddr;
    v.expBe = expBe; v.expWdata = expWdata; v.expWe = expWe;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one access from an IDLE negedge until the DONE/ERR cycle, acting as the memory.
  task automatic applyStimulus(input vec_t v);
    int  busyN;
    bit  finished;
    req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_lwhb = v.lwhb; req_swhb = v.swhb; req_lu = v.lu;
    req_valid = 1'b1; mem_ack = 1'b0; mem_rdata = v.rdata;
    obsStall = 0; obsRv = 1'b0; obsRdata = '0; obsMis = 1'b0; obsReq = 1'b0;
    obsAddr = '0; obsBe = '0; obsWdata = '0; obsWe = 1'b0; obsUnstable = 0; obsHung = 1'b0;
    busyN = 0;
    finished = 1'b0;
    for (int c = 0; c < 200 && !finished; c++) begin
      #1;
      if (mem_req) begin
        if (!obsReq) begin
          obsReq = 1'b1; obsAddr = mem_addr; obsBe = mem_be; obsWdata = mem_wdata; obsWe = mem_we;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} != {obsAddr, obsBe, obsWdata, obsWe}) begin
          obsUnstable++;
        end
        busyN++;
        mem_ack = (busyN > v.waitCycles);
      end
      if (stall) begin
        obsStall++;
      end else begin
        obsRv = rsp_valid; obsRdata = rsp_rdata; obsMis = misalign; finished = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    if (!finished) obsHung = 1'b1;
    req_valid = 1'b0;
    #1;
    obsAfter = {stall, rsp_valid, misalign, mem_req};
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawRv;
    bit sawReq;

    // size codes: 00 word, 01 half, 10 byte
    vecs.push_back(mk(0, 32'h100, 0, 2'b00, 2'b00, 0, 2, 32'h8899AABB, 4, 1, 32'h8899AABB, 0, 1, 32'h100, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h103, 0, 2'b10, 2'b00, 0, 0, 32'h80112233, 2, 1, 32'hFFFFFF80, 0, 1, 32'h100, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h103, 0, 2'b10, 2'b00, 1, 0, 32'h80112233, 2, 1, 32'h00000080, 0, 1, 32'h100, 4'h0, 0, 0));
    vecs.push_back(mk(1, 32'h202, 32'h0000BEEF, 2'b00, 2'b01, 0, 0, 32'h0, 2, 0, 32'h00000080, 0, 1, 32'h200, 4'hC, 32'hBEEFBEEF, 1));
    vecs.push_back(mk(0, 32'h101, 0, 2'b00, 2'b00, 0, 0, 32'h0, 1, 0, 32'h00000080, 1, 0, 32'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h102, 0, 2'b01, 2'b00, 0, 1, 32'h7FFF1234, 3, 1, 32'h00007FFF, 0, 1, 32'h100, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h102, 0, 2'b01, 2'b00, 0, 0, 32'h80001234, 2, 1, 32'hFFFF8000, 0, 1, 32'h100, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h100, 0, 2'b01, 2'b00, 1, 0, 32'h1234F00D, 2, 1, 32'h0000F00D, 0, 1, 32'h100, 4'h0, 0, 0));
    vecs.push_back(mk(1, 32'h101, 32'h123456A5, 2'b00, 2'b10, 0, 3, 32'h0, 5, 0, 32'h0000F00D, 0, 1, 32'h100, 4'h2, 32'hA5A5A5A5, 1));
    vecs.push_back(mk(1, 32'h104, 32'hCAFEF00D, 2'b00, 2'b00, 0, 0, 32'h0, 2, 0, 32'h0000F00D, 0, 1, 32'h104, 4'hF, 32'hCAFEF00D, 1));
    vecs.push_back(mk(1, 32'h203, 32'h00001111, 2'b00, 2'b01, 0, 0, 32'h0, 1, 0, 32'h0000F00D, 1, 0, 32'h0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h108, 0, 2'b11, 2'b00, 0, 1, 32'h13572468, 3, 1, 32'h13572468, 0, 1, 32'h108, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h10A, 0, 2'b11, 2'b00, 0, 0, 32'h0, 1, 0, 32'h13572468, 1, 0, 32'h0, 4'h0, 0, 0));
    vecs.push_back(mk(1, 32'h107, 32'h0000003C, 2'b00, 2'b10, 0, 0, 32'h0, 2, 0, 32'h13572468, 0, 1, 32'h104, 4'h8, 32'h3C3C3C3C, 1));
    vecs.push_back(mk(0, 32'h102, 0, 2'b10, 2'b00, 0, 0, 32'h00AB0000, 2, 1, 32'hFFFFFFAB, 0, 1, 32'h100, 4'h0, 0, 0));
    vecs.push_back(mk(0, 32'h101, 0, 2'b01, 2'b00, 0, 0, 32'h0, 1, 0, 32'hFFFFFFAB, 1, 0, 32'h0, 4'h0, 0, 0));
`ifdef LSU_TIMEOUT_EN
    vecs.push_back(mk(0, 32'h10C, 0, 2'b00, 2'b00, 0, 40, 32'h0BADF00D, 16, 0, 32'hDEADBEEF, 1, 1, 32'h10C, 4'h0, 0, 0));
`else
    vecs.push_back(mk(0, 32'h10C, 0, 2'b00, 2'b00, 0, 40, 32'h0BADF00D, 42, 1, 32'h0BADF00D, 0, 1, 32'h10C, 4'h0, 0, 0));
`endif

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_lwhb = '0; req_swhb = '0; req_lu = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset.stall", {31'b0, stall}, 0);
    checkOutput("reset.rsp", {30'b0, rsp_valid, misalign}, 0);
    checkOutput("reset.rdata", rsp_rdata, 0);
    checkOutput("reset.memReq", {31'b0, mem_req}, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d.hung", i), {31'b0, obsHung}, 0);
      checkOutput($sformatf("v%0d.stallCycles", i), obsStall, vecs[i].expStall);
      checkOutput($sformatf("v%0d.rspValid", i), {31'b0, obsRv}, {31'b0, vecs[i].expRv});
      checkOutput($sformatf("v%0d.rspRdata", i), obsRdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d.misalign", i), {31'b0, obsMis}, {31'b0, vecs[i].expMis});
      checkOutput($sformatf("v%0d.memReq", i), {31'b0, obsReq}, {31'b0, vecs[i].expReq});
      checkOutput($sformatf("v%0d.memAddr", i), obsAddr, vecs[i].expAddr);
      checkOutput($sformatf("v%0d.memBe", i), {28'b0, obsBe}, {28'b0, vecs[i].expBe});
      checkOutput($sformatf("v%0d.memWdata", i), obsWdata, vecs[i].expWdata);
      checkOutput($sformatf("v%0d.memWe", i), {31'b0, obsWe}, {31'b0, vecs[i].expWe});
      checkOutput($sformatf("v%0d.stable", i), obsUnstable, 0);
      checkOutput($sformatf("v%0d.afterPulse", i), {28'b0, obsAfter}, 0);
    end

    // Reset in the middle of BUSY, then a late ack that must be ignored.
    req_we = 1'b0; req_addr = 32'h100; req_lwhb = 2'b00; req_swhb = 2'b00; req_lu = 1'b0;
    req_valid = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(negedge clk);
    #1;
    checkOutput("rstBusy.preReq", {31'b0, mem_req}, 1);
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    checkOutput("rstBusy.memReq", {31'b0, mem_req}, 0);
    checkOutput("rstBusy.stall", {31'b0, stall}, 0);
    checkOutput("rstBusy.memAddr", mem_addr, 0);
    checkOutput("rstBusy.memBeWe", {27'b0, mem_be, mem_we}, 0);
    checkOutput("rstBusy.rdata", rsp_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFFFFFF;
    sawRv = 1'b0;
    sawReq = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      sawRv |= rsp_valid;
      sawReq |= mem_req;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    #1;
    checkOutput("lateAck.rspValid", {31'b0, sawRv}, 0);
    checkOutput("lateAck.memReq", {31'b0, sawReq}, 0);
    checkOutput("lateAck.rdata", rsp_rdata, 0);

    // The unit must still work normally after the aborted access.
    applyStimulus(vecs[0]);
    checkOutput("recover.stallCycles", obsStall, 4);
    checkOutput("recover.rspValid", {31'b0, obsRv}, 1);
    checkOutput("recover.rdata", obsRdata, 32'h8899AABB);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
